// File: rtl/mole_slot_arbiter_if.sv
// Bundles the start/request inputs and the slot, grant and round-status outputs of mole_slot_arbiter.
// The master modport is the side that drives start/req; the slave modport is the arbiter itself.
interface mole_slot_arbiter_if;
    logic       start_i;
    logic [1:0] req_i;
    logic [1:0] grant_o;
    logic [3:0] slot0_pos_o;
    logic [3:0] slot1_pos_o;
    logic       game_active_o;
    logic       game_over_o;
    logic [6:0] seconds_left_o;

    modport master (
        output start_i,
        output req_i,
        input  grant_o,
        input  slot0_pos_o,
        input  slot1_pos_o,
        input  game_active_o,
        input  game_over_o,
        input  seconds_left_o
    );

    modport slave (
        input  start_i,
        input  req_i,
        output grant_o,
        output slot0_pos_o,
        output slot1_pos_o,
        output game_active_o,
        output game_over_o,
        output seconds_left_o
    );
endinterface

// File: rtl/mole_slot_arbiter.sv
// Round timer plus round-robin hole allocator for the two player mole slots.
// Each grant picks an LFSR-seeded hole that avoids the other slot and the winner's own hole.
module mole_slot_arbiter #(
    parameter int unsigned NUM_HOLES     = 9,
    parameter int unsigned TICK_DIV      = 50_000_000,
    parameter int unsigned ROUND_SECONDS = 60,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic               clk,
    input logic               rst_n,
    mole_slot_arbiter_if.slave bus
);
    localparam int unsigned   TickW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [6:0]    RoundLoad = 7'(ROUND_SECONDS);
    localparam logic [3:0]    NoMole    = 4'hF;
    localparam logic [3:0]    HoleCount = 4'(NUM_HOLES);
    localparam logic [3:0]    HoleLast  = 4'(NUM_HOLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUNNING   = 2'd1,
        GAME_OVER = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [TickW-1:0]   tickCnt_q, tickCnt_d;
    logic [6:0]         secondsLeft_q, secondsLeft_d;
    logic               rrPtr_q, rrPtr_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [3:0]         slot0Pos_q, slot0Pos_d;
    logic [3:0]         slot1Pos_q, slot1Pos_d;
    logic [1:0]         grant_q, grant_d;
    logic               gameActive_q, gameActive_d;
    logic               gameOver_q, gameOver_d;

    logic [1:0]         eligible;
    logic               anyEligible;
    logic               winner;
    logic [3:0]         lfsrHole;
    logic [3:0]         ownPos;
    logic [3:0]         otherPos;
    logic [3:0]         pickedHole;

    function automatic logic [3:0] wrapInc(input logic [3:0] h);
        return (h == HoleLast) ? 4'd0 : h + 4'd1;
    endfunction

    // A player that was granted last cycle sits out one cycle so it can drop its request.
    assign eligible    = bus.req_i & ~grant_q;
    assign anyEligible = |eligible;
    assign winner      = (eligible == 2'b11) ? rrPtr_q : eligible[1];
    assign ownPos      = winner ? slot1Pos_q : slot0Pos_q;
    assign otherPos    = winner ? slot0Pos_q : slot1Pos_q;
    assign lfsrHole    = (lfsr_q[3:0] >= HoleCount) ? lfsr_q[3:0] - HoleCount : lfsr_q[3:0];

    // Two exclusions at most, so two forward steps always land on a free hole.
    always_comb begin
        pickedHole = lfsrHole;
        for (int k = 0; k < 2; k++) begin
            if (pickedHole == ownPos || pickedHole == otherPos) begin
                pickedHole = wrapInc(pickedHole);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        tickCnt_d     = tickCnt_q;
        secondsLeft_d = secondsLeft_q;
        rrPtr_d       = rrPtr_q;
        slot0Pos_d    = slot0Pos_q;
        slot1Pos_d    = slot1Pos_q;
        grant_d       = 2'b00;
        lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        if (bus.start_i) begin
            state_d       = RUNNING;
            tickCnt_d     = '0;
            secondsLeft_d = RoundLoad;
            slot0Pos_d    = NoMole;
            slot1Pos_d    = NoMole;
        end else begin
            case (state_q)
                RUNNING: begin
                    if (tickCnt_q == TickLast) begin
                        tickCnt_d     = '0;
                        secondsLeft_d = secondsLeft_q - 7'd1;
                        if (secondsLeft_q == 7'd1) begin
                            state_d    = GAME_OVER;
                            slot0Pos_d = NoMole;
                            slot1Pos_d = NoMole;
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + TickW'(1);
                    end
                    // Round end on this edge suppresses any grant.
                    if (state_d == RUNNING && anyEligible) begin
                        rrPtr_d = ~winner;
                        if (winner) begin
                            grant_d    = 2'b10;
                            slot1Pos_d = pickedHole;
                        end else begin
                            grant_d    = 2'b01;
                            slot0Pos_d = pickedHole;
                        end
                    end
                end
                IDLE, GAME_OVER: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        gameActive_d = (state_d == RUNNING);
        gameOver_d   = (state_d == GAME_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tickCnt_q     <= '0;
            secondsLeft_q <= 7'd0;
            rrPtr_q       <= 1'b0;
            lfsr_q        <= LFSR_SEED;
            slot0Pos_q    <= NoMole;
            slot1Pos_q    <= NoMole;
            grant_q       <= 2'b00;
            gameActive_q  <= 1'b0;
            gameOver_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            tickCnt_q     <= tickCnt_d;
            secondsLeft_q <= secondsLeft_d;
            rrPtr_q       <= rrPtr_d;
            lfsr_q        <= lfsr_d;
            slot0Pos_q    <= slot0Pos_d;
            slot1Pos_q    <= slot1Pos_d;
            grant_q       <= grant_d;
            gameActive_q  <= gameActive_d;
            gameOver_q    <= gameOver_d;
        end
    end

    assign bus.grant_o        = grant_q;
    assign bus.slot0_pos_o    = slot0Pos_q;
    assign bus.slot1_pos_o    = slot1Pos_q;
    assign bus.game_active_o  = gameActive_q;
    assign bus.game_over_o    = gameOver_q;
    assign bus.seconds_left_o = secondsLeft_q;
endmodule
